// File: rtl/hilo_div_sequencer_if.sv
// ============================================================================
// Module      : hilo_div_sequencer_if
// Description : EX-stage DIV/MFHI/MFLO handshake and HI/LO result bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hilo_div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             ex_valid;
    logic             ex_is_div;
    logic             ex_is_mfhi;
    logic             ex_is_mflo;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_data;

    modport master (
        output ex_valid, ex_is_div, ex_is_mfhi, ex_is_mflo, rs_val, rt_val,
        input  stall, busy, hi, lo, mf_data
    );

    modport slave (
        input  ex_valid, ex_is_div, ex_is_mfhi, ex_is_mflo, rs_val, rt_val,
        output stall, busy, hi, lo, mf_data
    );
endinterface

`default_nettype wire

// File: rtl/hilo_div_sequencer.sv
// ============================================================================
// Module      : hilo_div_sequencer
// Description : Multi-cycle signed restoring divider owning the HI/LO pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hilo_div_sequencer_if.slave   bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUSY  = 2'd1;
    localparam logic [1:0] c_FIXUP = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_dvd_orig;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_qsign;
    logic             r_rsign;
    logic             r_dz;

    logic             w_busy;
    logic             w_div_req;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_lo_res;
    logic [WIDTH-1:0] w_hi_res;

    assign w_busy    = (r_state != c_IDLE);
    assign w_div_req = bus.ex_valid & bus.ex_is_div;

    assign w_rs_mag = bus.rs_val[WIDTH-1] ? -bus.rs_val : bus.rs_val;
    assign w_rt_mag = bus.rt_val[WIDTH-1] ? -bus.rt_val : bus.rt_val;

    // Dividend bits stream out of the top of r_quo while quotient bits enter at the bottom.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_borrow   = w_diff[WIDTH];
    assign w_rem_next = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];

    assign w_lo_res = r_dz ? {WIDTH{1'b1}} : (r_qsign ? -r_quo : r_quo);
    assign w_hi_res = r_dz ? r_dvd_orig    : (r_rsign ? -r_rem : r_rem);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_dvd_orig <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_qsign    <= 1'b0;
            r_rsign    <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_div_req) begin
                        r_state    <= c_BUSY;
                        r_cnt      <= '0;
                        r_rem      <= '0;
                        r_quo      <= w_rs_mag;
                        r_dvs      <= w_rt_mag;
                        r_dvd_orig <= bus.rs_val;
                        r_qsign    <= bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1];
                        r_rsign    <= bus.rs_val[WIDTH-1];
                        r_dz       <= (bus.rt_val == '0);
                    end
                end
                c_BUSY: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= c_FIXUP;
                    end
                end
                c_FIXUP: begin
                    r_hi    <= w_hi_res;
                    r_lo    <= w_lo_res;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = w_busy;
    assign bus.stall   = bus.ex_valid & w_busy & (bus.ex_is_div | bus.ex_is_mfhi | bus.ex_is_mflo);
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign bus.mf_data = bus.ex_is_mfhi ? r_hi : r_lo;

endmodule

`default_nettype wire

// File: tb/tb_hilo_div_sequencer.sv
// ============================================================================
// Module      : tb_hilo_div_sequencer
// Description : Directed scoreboard bench for the HI/LO divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_div_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    logic [63:0] sb_q[$];

    hilo_div_sequencer_if #(.WIDTH(32)) bus ();

    hilo_div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo}: C-style truncating signed divide done in 64 bits.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic sb_check(input string tag);
        logic [63:0] e;
        chk({tag, ":sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, ":lo"}, bus.lo, e[31:0]);
            chk({tag, ":hi"}, bus.hi, e[63:32]);
        end
    endtask

    task automatic idle_inputs();
        bus.ex_valid   = 1'b0;
        bus.ex_is_div  = 1'b0;
        bus.ex_is_mfhi = 1'b0;
        bus.ex_is_mflo = 1'b0;
    endtask

    task automatic drive_div(input logic [31:0] a, input logic [31:0] b);
        bus.ex_valid  = 1'b1;
        bus.ex_is_div = 1'b1;
        bus.rs_val    = a;
        bus.rt_val    = b;
    endtask

    // Called at a negedge with the sequencer idle.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input string tag);
        int n;
        sb_q.push_back(model(a, b));
        drive_div(a, b);
        @(negedge clk);
        chk({tag, ":busy_start"}, 32'(bus.busy), 32'd1);
        idle_inputs();
        bus.ex_valid = 1'b1;
        #1;
        chk({tag, ":alu_no_stall"}, 32'(bus.stall), 32'd0);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, ":busy_cycles"}, n, 32'd33);
        sb_check(tag);
        idle_inputs();
    endtask

    initial begin
        int n;
        logic [31:0] d1234;
        rst_n = 1'b0;
        idle_inputs();
        bus.rs_val = '0;
        bus.rt_val = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        rst_n = 1'b1;
        bus.ex_valid   = 1'b1;
        bus.ex_is_mfhi = 1'b1;
        #1;
        chk("idle_stall", 32'(bus.stall), 32'd0);
        chk("idle_mf_data", bus.mf_data, 32'd0);
        idle_inputs();

        // Div strobe without ex_valid must not start a divide.
        bus.ex_is_div = 1'b1;
        bus.rs_val    = 32'd100;
        bus.rt_val    = 32'd7;
        @(negedge clk);
        chk("invalid_no_capture", 32'(bus.busy), 32'd0);
        idle_inputs();

        run_div(32'd100, 32'd7, "div_100_7");
        chk("div_100_7:lo_const", bus.lo, 32'd14);
        run_div(32'hFFFF_FFF9, 32'd2, "div_m7_2");
        chk("div_m7_2:hi_const", bus.hi, 32'hFFFF_FFFF);
        run_div(32'd7, 32'hFFFF_FFFE, "div_7_m2");
        chk("div_7_m2:lo_const", bus.lo, 32'hFFFF_FFFD);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        chk("div_ovf:lo_const", bus.lo, 32'h8000_0000);
        chk("div_ovf:hi_const", bus.hi, 32'd0);
        run_div(32'd5, 32'd0, "div_zero");
        chk("div_zero:lo_const", bus.lo, 32'hFFFF_FFFF);
        bus.ex_valid   = 1'b1;
        bus.ex_is_mfhi = 1'b1;
        #1;
        chk("mfhi_idle", bus.mf_data, 32'd5);
        bus.ex_is_mfhi = 1'b0;
        bus.ex_is_mflo = 1'b1;
        #1;
        chk("mflo_idle", bus.mf_data, 32'hFFFF_FFFF);
        idle_inputs();
        @(negedge clk);

        // MFLO waiting on an in-flight divide.
        sb_q.push_back(model(32'd100, 32'd7));
        drive_div(32'd100, 32'd7);
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        bus.ex_valid   = 1'b1;
        bus.ex_is_mflo = 1'b1;
        #1;
        n = 0;
        while (bus.stall && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("mflo_stall_cycles", n, 32'd31);
        chk("mflo_data", bus.mf_data, 32'd14);
        sb_check("mflo_wait");
        idle_inputs();
        @(negedge clk);

        // Back-to-back DIV: second one held off until the first completes.
        sb_q.push_back(model(32'd100, 32'd7));
        sb_q.push_back(model(32'd9, 32'd4));
        drive_div(32'd100, 32'd7);
        @(negedge clk);
        drive_div(32'd9, 32'd4);
        #1;
        n = 0;
        while (bus.stall && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_stall_cycles", n, 32'd33);
        chk("b2b_gap_idle", 32'(bus.busy), 32'd0);
        sb_check("b2b_first");
        @(negedge clk);
        chk("b2b_second_busy", 32'(bus.busy), 32'd1);
        idle_inputs();
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_second_cycles", n, 32'd33);
        sb_check("b2b_second");
        chk("b2b_lo_const", bus.lo, 32'd2);

        // Reset in the middle of a divide.
        d1234 = 32'h1234 * 32'h1236;
        run_div(d1234, 32'h1235, "preload");
        chk("preload:hi_const", bus.hi, 32'h1234);
        chk("preload:lo_const", bus.lo, 32'h1234);
        drive_div(32'd100, 32'd7);
        @(negedge clk);
        idle_inputs();
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.ex_valid   = 1'b1;
        bus.ex_is_mflo = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        chk("abort_stall", 32'(bus.stall), 32'd0);
        idle_inputs();
        @(negedge clk);
        run_div(32'd100, 32'd7, "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
